// File: rtl/tracker_sequencer_if.sv
// Host-side bus of the pattern sequencer: pattern writes, playback control,
// and the note/speed outputs that feed the tracker synthesiser.
interface tracker_sequencer_if #(
  parameter int AW = 6
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          start;
  logic          stop;
  logic [AW-1:0] start_row;
  logic          loop_en;
  logic [7:0]    row_ticks;
  logic [3:0]    speed_in;

  logic [7:0]    pitch;
  logic [1:0]    instrument;
  logic [3:0]    volume;
  logic [3:0]    speed;
  logic [AW-1:0] row;
  logic          playing;
  logic          row_strobe;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, start_row, loop_en, row_ticks, speed_in,
    input  pitch, instrument, volume, speed, row, playing, row_strobe, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, start_row, loop_en, row_ticks, speed_in,
    output pitch, instrument, volume, speed, row, playing, row_strobe, done
  );
endinterface

// File: rtl/tracker_sequencer.sv
// Pattern sequencer: steps through a writable row RAM at a programmable tempo
// and decodes each row into NOTE / HOLD / OFF / END for the tracker synthesiser.
module tracker_sequencer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst,
  tracker_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOTE,
    CMD_HOLD,
    CMD_OFF,
    CMD_END
  } cmd_e;

  state_e        r_state;
  state_e        w_next;

  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_rdata;

  logic [AW-1:0] r_row;
  logic [7:0]    r_pitch;
  logic [1:0]    r_instr;
  logic [3:0]    r_vol;
  logic [3:0]    r_speed;
  logic [7:0]    r_ticks;
  logic          r_strobe;
  logic          r_done;
  logic          r_end_chain;

  cmd_e          w_cmd;
  logic [7:0]    w_ticks_load;
  logic          w_begin;
  logic          w_enter_play;
  logic          w_jump;
  logic          w_finish;
  logic          w_advance;
  logic          w_abort;

  assign w_cmd        = cmd_e'(r_rdata[15:14]);
  assign w_ticks_load = (bus.row_ticks == 8'd0) ? 8'd0 : bus.row_ticks - 8'd1;

  // Pattern RAM: non-blocking read and write give read-before-write on collision.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
    if (r_state == S_FETCH) begin
      r_rdata <= r_mem[r_row];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_begin      = 1'b0;
    w_enter_play = 1'b0;
    w_jump       = 1'b0;
    w_finish     = 1'b0;
    w_advance    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_begin = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_cmd == CMD_END) begin
          // A second END without an intervening PLAY finishes, breaking END->END loops.
          if (bus.loop_en && !r_end_chain) begin
            w_jump = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_finish = 1'b1;
            w_next   = S_IDLE;
          end
        end else begin
          w_enter_play = 1'b1;
          w_next       = S_PLAY;
        end
      end
      S_PLAY: begin
        if (r_ticks == 8'd0) begin
          w_advance = 1'b1;
          w_next    = S_FETCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (bus.stop && (r_state != S_IDLE)) begin
      w_next       = S_IDLE;
      w_abort      = 1'b1;
      w_enter_play = 1'b0;
      w_jump       = 1'b0;
      w_finish     = 1'b0;
      w_advance    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row       <= '0;
      r_pitch     <= '0;
      r_instr     <= '0;
      r_vol       <= '0;
      r_speed     <= '0;
      r_ticks     <= '0;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
      r_end_chain <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (w_begin) begin
        r_row   <= bus.start_row;
        r_speed <= bus.speed_in;
      end
      if (w_enter_play) begin
        r_ticks     <= w_ticks_load;
        r_strobe    <= 1'b1;
        r_end_chain <= 1'b0;
        case (w_cmd)
          CMD_NOTE: begin
            r_pitch <= r_rdata[7:0];
            r_instr <= r_rdata[13:12];
            r_vol   <= r_rdata[11:8];
          end
          CMD_OFF: r_vol <= '0;
          default: ;
        endcase
      end
      if (w_jump) begin
        r_row       <= r_rdata[AW-1:0];
        r_end_chain <= 1'b1;
      end
      if (w_finish) begin
        r_vol       <= '0;
        r_done      <= 1'b1;
        r_end_chain <= 1'b0;
      end
      if (w_abort) begin
        r_vol       <= '0;
        r_end_chain <= 1'b0;
      end
      if ((r_state == S_PLAY) && !w_abort && (r_ticks != 8'd0)) begin
        r_ticks <= r_ticks - 8'd1;
      end
      if (w_advance) begin
        r_row <= r_row + AW'(1);
      end
    end
  end

  assign bus.pitch      = r_pitch;
  assign bus.instrument = r_instr;
  assign bus.volume     = r_vol;
  assign bus.speed      = r_speed;
  assign bus.row        = r_row;
  assign bus.playing    = (r_state != S_IDLE);
  assign bus.row_strobe = r_strobe;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Bench for tracker_sequencer: a row-walking reference model predicts strobe
// times, row outputs and the finish cycle for each playback run.
module tb_tracker_sequencer;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int MAXC  = 128;

  typedef struct {
    int          cyc;
    logic [20:0] obs;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tracker_sequencer_if #(.AW(AW)) bus ();
  tracker_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  logic [15:0]   mmem [DEPTH];
  logic [7:0]    m_pitch;
  logic [1:0]    m_instr;
  logic [3:0]    m_vol;
  logic [3:0]    m_speed;
  ev_t           exp_q[$];
  int            exp_done;

  logic          cap_strobe [MAXC];
  logic          cap_done   [MAXC];
  logic          cap_play   [MAXC];
  logic [AW-1:0] cap_row    [MAXC];
  logic [20:0]   cap_obs    [MAXC];
  logic [18:0]   cap_tail   [MAXC];

  function automatic logic [15:0] note(input logic [1:0] ins, input logic [3:0] v, input logic [7:0] p);
    return {2'd0, ins, v, p};
  endfunction

  function automatic logic [15:0] rand_word();
    int         k;
    logic [1:0] cmd;
    k = $urandom_range(0, 9);
    cmd = (k < 5) ? 2'd0 : (k < 7) ? 2'd1 : (k < 8) ? 2'd2 : 2'd3;
    return {cmd, 14'($urandom)};
  endfunction

  task automatic write_row(input int a, input logic [15:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    mmem[a]     = d;
  endtask

  // Walks the pattern row by row: each played row costs ticks+2 cycles,
  // each END jump costs 2, and only events visible within the window count.
  task automatic model_run(input int sr, input bit le, input int rt, input int win);
    int          d;
    int          r;
    int          t;
    bit          chain;
    logic [15:0] w;
    d = 2; r = sr; chain = 0;
    t = (rt == 0) ? 1 : rt;
    exp_q.delete();
    exp_done = -1;
    while (d + 1 <= win) begin
      w = mmem[r];
      if (w[15:14] == 2'd3) begin
        if (le && !chain) begin
          r = int'(w[AW-1:0]); chain = 1; d += 2;
        end else begin
          m_vol = 4'd0; exp_done = d + 1;
          break;
        end
      end else begin
        chain = 0;
        if (w[15:14] == 2'd0) begin
          m_pitch = w[7:0]; m_instr = w[13:12]; m_vol = w[11:8];
        end else if (w[15:14] == 2'd2) begin
          m_vol = 4'd0;
        end
        exp_q.push_back('{d + 1, {1'b1, AW'(r), m_pitch, m_instr, m_vol}});
        d += t + 2;
        r = (r + 1) % DEPTH;
      end
    end
    if (exp_done < 0) m_vol = 4'd0;
  endtask

  // Starts playback, records win cycles, stops if still playing, records 3 more.
  task automatic launch(input int sr, input bit le, input int rt, input logic [3:0] sp, input int win);
    model_run(sr, le, rt, win);
    m_speed = sp;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.start_row = AW'(sr);
    bus.loop_en   = le;
    bus.row_ticks = 8'(rt);
    bus.speed_in  = sp;
    for (int c = 1; c <= win + 3; c++) begin
      @(negedge clk);
      cap_strobe[c] = bus.row_strobe;
      cap_done[c]   = bus.done;
      cap_play[c]   = bus.playing;
      cap_row[c]    = bus.row;
      cap_obs[c]    = {bus.row_strobe, bus.row, bus.pitch, bus.instrument, bus.volume};
      cap_tail[c]   = {bus.playing, bus.pitch, bus.instrument, bus.volume, bus.speed};
      bus.start     = 1'b0;
      bus.stop      = (c == win) && (exp_done < 0);
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0; bus.stop = 0;
    bus.start_row = '0; bus.loop_en = 0; bus.row_ticks = 8'd1; bus.speed_in = 4'd0;
    m_pitch = 0; m_instr = 0; m_vol = 0; m_speed = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pitch, bus.instrument, bus.volume, bus.speed, bus.row, bus.playing, bus.row_strobe, bus.done} !== '0) begin
      errors++; $display("FAIL reset_hold outputs=%h required 0", {bus.pitch, bus.instrument, bus.volume, bus.speed, bus.row, bus.playing, bus.row_strobe, bus.done});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.pitch, bus.instrument, bus.volume, bus.speed, bus.row, bus.playing, bus.row_strobe, bus.done} !== '0) begin
      errors++; $display("FAIL reset_release outputs=%h required 0", {bus.pitch, bus.instrument, bus.volume, bus.speed, bus.row, bus.playing, bus.row_strobe, bus.done});
    end
    for (int a = 0; a < DEPTH; a++) write_row(a, rand_word());
  endtask

  task automatic write_basic(input logic [7:0] end_word_lo);
    write_row(0, note(2'd0, 4'd15, 8'd10));
    write_row(1, note(2'd1, 4'd15, 8'd20));
    write_row(2, note(2'd2, 4'd15, 8'd30));
    write_row(3, note(2'd3, 4'd15, 8'd40));
    write_row(4, {2'd3, 6'd0, end_word_lo});
  endtask

  task automatic test_basic();
    int n, k, nd;
    write_basic(8'd0);
    launch(0, 0, 4, 4'($urandom), 40);
    n = 0; k = 0; nd = 0;
    for (int c = 1; c <= 40; c++) begin n += cap_strobe[c] ? 1 : 0; k += cap_play[c] ? 1 : 0; end
    for (int c = 1; c <= 43; c++) nd += cap_done[c] ? 1 : 0;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL basic_strobes got %0d exp %0d", n, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (cap_obs[exp_q[i].cyc] !== exp_q[i].obs) begin errors++; $display("FAIL basic_row cyc %0d got %h exp %h", exp_q[i].cyc, cap_obs[exp_q[i].cyc], exp_q[i].obs); end
    end
    checks++; if (nd != ((exp_done >= 0) ? 1 : 0)) begin errors++; $display("FAIL basic_done_count got %0d exp %0d", nd, (exp_done >= 0) ? 1 : 0); end
    checks++; if (k != ((exp_done >= 0) ? exp_done - 1 : 40)) begin errors++; $display("FAIL basic_playing got %0d exp %0d", k, (exp_done >= 0) ? exp_done - 1 : 40); end
    checks++; if (cap_tail[41] !== {1'b0, m_pitch, m_instr, m_vol, m_speed}) begin errors++; $display("FAIL basic_final got %h exp %h", cap_tail[41], {1'b0, m_pitch, m_instr, m_vol, m_speed}); end
    checks++;
    if ({cap_strobe[3], cap_strobe[9], cap_strobe[15], cap_strobe[21], cap_done[27], cap_play[27], cap_obs[27][3:0]} !== {5'b11111, 1'b0, 4'd0}) begin
      errors++; $display("FAIL basic_timing got %b exp 1111100000", {cap_strobe[3], cap_strobe[9], cap_strobe[15], cap_strobe[21], cap_done[27], cap_play[27], cap_obs[27][3:0]});
    end
  endtask

  task automatic test_loop();
    int n, c3, c1;
    write_basic(8'd1);
    launch(0, 1, 4, 4'($urandom), 60);
    n = 0;
    for (int c = 1; c <= 60; c++) n += cap_strobe[c] ? 1 : 0;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL loop_strobes got %0d exp %0d", n, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (cap_obs[exp_q[i].cyc] !== exp_q[i].obs) begin errors++; $display("FAIL loop_row cyc %0d got %h exp %h", exp_q[i].cyc, cap_obs[exp_q[i].cyc], exp_q[i].obs); end
    end
    checks++; if (cap_tail[61] !== {1'b0, m_pitch, m_instr, m_vol, m_speed}) begin errors++; $display("FAIL loop_stop got %h exp %h", cap_tail[61], {1'b0, m_pitch, m_instr, m_vol, m_speed}); end
    c3 = -1; c1 = -1;
    for (int c = 1; c <= 60; c++) begin
      if (cap_strobe[c] && c3 >= 0 && c1 < 0) c1 = c;
      if (cap_strobe[c] && cap_row[c] == AW'(3) && c3 < 0) c3 = c;
    end
    checks++;
    if (c3 < 0 || c1 < 0 || (c1 - c3) != 8 || cap_row[c1] != AW'(1)) begin
      errors++; $display("FAIL loop_gap row3 at %0d next at %0d required gap 8 to row 1", c3, c1);
    end
  endtask

  task automatic test_hold_off();
    int n, t, nd;
    logic [1:0] ins;
    ins = 2'($urandom);
    t = $urandom_range(1, 5);
    write_row(0, note(ins, 4'd9, 8'd50));
    write_row(1, {2'd1, 14'($urandom)});
    write_row(2, {2'd2, 14'($urandom)});
    write_row(3, {2'd3, 14'($urandom)});
    launch(0, 0, t, 4'($urandom), 40);
    n = 0; nd = 0;
    for (int c = 1; c <= 40; c++) n += cap_strobe[c] ? 1 : 0;
    for (int c = 1; c <= 43; c++) nd += cap_done[c] ? 1 : 0;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL hold_strobes got %0d exp %0d", n, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (cap_obs[exp_q[i].cyc] !== exp_q[i].obs) begin errors++; $display("FAIL hold_row cyc %0d got %h exp %h", exp_q[i].cyc, cap_obs[exp_q[i].cyc], exp_q[i].obs); end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL hold_done_count got %0d exp 1", nd); end
    checks++;
    if ({cap_obs[3][13:6], cap_obs[5 + t][13:6], cap_obs[7 + 2 * t][13:6], cap_obs[3][3:0], cap_obs[5 + t][3:0], cap_obs[7 + 2 * t][3:0]} !== {8'd50, 8'd50, 8'd50, 4'd9, 4'd9, 4'd0}) begin
      errors++; $display("FAIL hold_values pitch %0d/%0d/%0d vol %0d/%0d/%0d required 50/50/50 9/9/0", cap_obs[3][13:6], cap_obs[5 + t][13:6], cap_obs[7 + 2 * t][13:6], cap_obs[3][3:0], cap_obs[5 + t][3:0], cap_obs[7 + 2 * t][3:0]);
    end
  endtask

  task automatic test_end_chain();
    int n, nd;
    write_row(5, {2'd3, 6'($urandom), 2'($urandom), 6'd6});
    write_row(6, {2'd3, 14'($urandom)});
    launch(5, 1, $urandom_range(0, 4), 4'($urandom), 20);
    n = 0; nd = 0;
    for (int c = 1; c <= 20; c++) n += cap_strobe[c] ? 1 : 0;
    for (int c = 1; c <= 23; c++) nd += cap_done[c] ? 1 : 0;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL chain_strobes got %0d exp %0d", n, exp_q.size()); end
    checks++; if (nd != ((exp_done >= 0) ? 1 : 0)) begin errors++; $display("FAIL chain_done_count got %0d exp %0d", nd, (exp_done >= 0) ? 1 : 0); end
    checks++; if ({cap_done[5], cap_play[5], cap_play[4]} !== 3'b101) begin errors++; $display("FAIL chain_done_time got %b exp 101", {cap_done[5], cap_play[5], cap_play[4]}); end
    checks++; if (cap_tail[21] !== {1'b0, m_pitch, m_instr, m_vol, m_speed}) begin errors++; $display("FAIL chain_final got %h exp %h", cap_tail[21], {1'b0, m_pitch, m_instr, m_vol, m_speed}); end
  endtask

  task automatic test_stop();
    int nd;
    write_basic(8'd0);
    launch(0, 0, 4, 4'($urandom), 16);
    nd = 0;
    for (int c = 1; c <= 19; c++) nd += cap_done[c] ? 1 : 0;
    foreach (exp_q[i]) begin
      checks++;
      if (cap_obs[exp_q[i].cyc] !== exp_q[i].obs) begin errors++; $display("FAIL stop_row cyc %0d got %h exp %h", exp_q[i].cyc, cap_obs[exp_q[i].cyc], exp_q[i].obs); end
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL stop_done got %0d exp 0", nd); end
    checks++;
    if ({cap_play[17], cap_row[17], cap_obs[17][13:6], cap_obs[17][3:0]} !== {1'b0, AW'(2), 8'd30, 4'd0}) begin
      errors++; $display("FAIL stop_state play %b row %0d pitch %0d vol %0d required 0 2 30 0", cap_play[17], cap_row[17], cap_obs[17][13:6], cap_obs[17][3:0]);
    end
  endtask

  task automatic test_start_stop();
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1; bus.start_row = '0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      k += (bus.playing || bus.row_strobe || bus.done) ? 1 : 0;
    end
    checks++; if (k != 0) begin errors++; $display("FAIL start_stop active cycles %0d required 0", k); end
  endtask

  task automatic test_ticks_zero();
    int n;
    write_basic(8'd0);
    launch(0, 0, 0, 4'($urandom), 30);
    n = 0;
    for (int c = 1; c <= 30; c++) n += cap_strobe[c] ? 1 : 0;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL t0_strobes got %0d exp %0d", n, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (cap_obs[exp_q[i].cyc] !== exp_q[i].obs) begin errors++; $display("FAIL t0_row cyc %0d got %h exp %h", exp_q[i].cyc, cap_obs[exp_q[i].cyc], exp_q[i].obs); end
    end
    checks++;
    if ({cap_strobe[3], cap_strobe[6], cap_strobe[9], cap_strobe[12], cap_done[15]} !== 5'b11111) begin
      errors++; $display("FAIL t0_period got %b exp 11111", {cap_strobe[3], cap_strobe[6], cap_strobe[9], cap_strobe[12], cap_done[15]});
    end
  endtask

  task automatic test_wrap();
    int n, t;
    t = $urandom_range(1, 4);
    write_row(DEPTH - 1, note(2'($urandom), 4'($urandom), 8'($urandom)));
    write_row(0, note(2'($urandom), 4'($urandom), 8'($urandom)));
    write_row(1, {2'd3, 14'($urandom)});
    launch(DEPTH - 1, 0, t, 4'($urandom), 30);
    n = 0;
    for (int c = 1; c <= 30; c++) n += cap_strobe[c] ? 1 : 0;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL wrap_strobes got %0d exp %0d", n, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (cap_obs[exp_q[i].cyc] !== exp_q[i].obs) begin errors++; $display("FAIL wrap_row cyc %0d got %h exp %h", exp_q[i].cyc, cap_obs[exp_q[i].cyc], exp_q[i].obs); end
    end
    checks++;
    if ({cap_strobe[3], cap_row[3], cap_strobe[5 + t], cap_row[5 + t]} !== {1'b1, AW'(DEPTH - 1), 1'b1, AW'(0)}) begin
      errors++; $display("FAIL wrap_next rows %0d then %0d required %0d then 0", cap_row[3], cap_row[5 + t], DEPTH - 1);
    end
  endtask

  task automatic test_random();
    int n, k, nd;
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 10; j++) write_row($urandom_range(0, DEPTH - 1), rand_word());
      launch($urandom_range(0, DEPTH - 1), 1'($urandom), $urandom_range(0, 4), 4'($urandom), 60);
      n = 0; k = 0; nd = 0;
      for (int c = 1; c <= 60; c++) begin n += cap_strobe[c] ? 1 : 0; k += cap_play[c] ? 1 : 0; end
      for (int c = 1; c <= 63; c++) nd += cap_done[c] ? 1 : 0;
      checks++; if (n != exp_q.size()) begin errors++; $display("FAIL rand%0d_strobes got %0d exp %0d", it, n, exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (cap_obs[exp_q[i].cyc] !== exp_q[i].obs) begin errors++; $display("FAIL rand%0d_row cyc %0d got %h exp %h", it, exp_q[i].cyc, cap_obs[exp_q[i].cyc], exp_q[i].obs); end
      end
      checks++; if (nd != ((exp_done >= 0) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_done_count got %0d exp %0d", it, nd, (exp_done >= 0) ? 1 : 0); end
      checks++; if (k != ((exp_done >= 0) ? exp_done - 1 : 60)) begin errors++; $display("FAIL rand%0d_playing got %0d exp %0d", it, k, (exp_done >= 0) ? exp_done - 1 : 60); end
      checks++; if (cap_tail[61] !== {1'b0, m_pitch, m_instr, m_vol, m_speed}) begin errors++; $display("FAIL rand%0d_final got %h exp %h", it, cap_tail[61], {1'b0, m_pitch, m_instr, m_vol, m_speed}); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] v;
    int k;
    v = 4'($urandom_range(1, 15));
    write_row(0, note(2'($urandom), v, 8'h80 | 8'($urandom)));
    write_row(1, note(2'($urandom), v, 8'h80 | 8'($urandom)));
    @(negedge clk);
    bus.start = 1'b1; bus.start_row = '0; bus.loop_en = 1'b0; bus.row_ticks = 8'd8; bus.speed_in = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({bus.playing, bus.volume} !== {1'b1, v}) begin errors++; $display("FAIL areset_pre play %b vol %0d required 1 %0d", bus.playing, bus.volume, v); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.pitch, bus.instrument, bus.volume, bus.speed, bus.row, bus.playing, bus.row_strobe, bus.done} !== '0) begin
      errors++; $display("FAIL areset_now outputs=%h required 0", {bus.pitch, bus.instrument, bus.volume, bus.speed, bus.row, bus.playing, bus.row_strobe, bus.done});
    end
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      k += (bus.playing || bus.row_strobe || bus.done) ? 1 : 0;
    end
    checks++; if (k != 0) begin errors++; $display("FAIL areset_idle active cycles %0d required 0", k); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_hold_off();
    test_end_chain();
    test_stop();
    test_start_stop();
    test_ticks_zero();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tracker_sequencer.md
# tracker_sequencer

Pattern sequencer that drives the `tracker` synthesiser's note/speed inputs. It holds a writable pattern RAM of rows, steps through it at a programmable tempo, and decodes each row into a note, hold, note-off or jump command. It sits between the host/loader and `tracker`. Its outputs are assembled into `note_tp` (pitch, instrument, volume) and `speed` at the top level.

## Interface
Parameters:
- `DEPTH`, 64: pattern rows; power of two, ≥ 4.
- `AW`, `$clog2(DEPTH)`: row address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  pattern write strobe.
- `wr_addr`  in  AW  write row address.
- `wr_data`  in  16  row word: cmd[15:14], instr[13:12], vol[11:8], pitch[7:0].
- `start`  in  1  begin playback from `start_row`; ignored unless IDLE.
- `stop`  in  1  abort playback.
- `start_row`  in  AW  first row.
- `loop_en`  in  1  END rows jump when 1, finish when 0.
- `row_ticks`  in  8  PLAY cycles per row; 0 is treated as 1.
- `speed_in`  in  4  latched into `speed` on `start`.
- `pitch`  out  8  current pitch.
- `instrument`  out  2  INSTR_SIN=0, INSTR_SQUARE=1, INSTR_SAW=2, INSTR_RAND=3.
- `volume`  out  4  current volume.
- `speed`  out  4  oscillator speed for tracker.
- `row`  out  AW  address of the row being played.
- `playing`  out  1  high in FETCH/DECODE/PLAY.
- `row_strobe`  out  1  one-cycle pulse when a new row enters PLAY.
- `done`  out  1  one-cycle pulse on natural end (not on `stop`).

## Operation
- RAM: DEPTH×16, one synchronous write port and one synchronous read port, read-before-write on an address collision. Contents are not reset.
- Row commands:
  - 0 NOTE: load pitch, instrument and volume.
  - 1 HOLD: keep the previous outputs.
  - 2 OFF: volume←0; pitch and instrument held.
  - 3 END: pitch[AW-1:0] is the jump target.
- FSM states:
  - IDLE: on `start`, set `row`←`start_row`, `speed`←`speed_in`, go to FETCH.
  - FETCH: present `row` to the RAM; go to DECODE.
  - DECODE, NOTE/HOLD/OFF rows: update outputs, load tick counter with max(`row_ticks`,1)−1, pulse `row_strobe`, go to PLAY.
  - DECODE, END row with `loop_en`=1: `row`←target, go to FETCH. Outputs unchanged, no strobe.
  - DECODE, END row with `loop_en`=0: volume←0, pulse `done`, go to IDLE.
  - DECODE, second END decoded with no PLAY in between: treated as `loop_en`=0. This prevents a livelock on END→END chains.
  - PLAY: count down; at 0, `row`←`row`+1 (wraps DEPTH−1→0), go to FETCH.
- `stop` in any non-IDLE state: next state IDLE, volume←0, no `done`. Pitch, instrument, speed and row are held.
- `start` and `stop` in the same cycle: `stop` wins and the block stays IDLE.
- Writes are accepted in every state. A row rewritten during its own PLAY does not affect the current outputs.

## Timing
- Reset values: all outputs 0, state IDLE, tick counter 0, END-chain flag 0.
- `start` sampled at edge N: FETCH at N+1, DECODE at N+2. Outputs and `row_strobe` are visible at N+3, which is the first PLAY cycle.
- Row period: max(`row_ticks`,1)+2 cycles. Outputs hold through the following FETCH/DECODE.
- END jump adds 2 cycles (FETCH+DECODE) with no PLAY.
- `stop` sampled at edge N: `playing`=0 and `volume`=0 at N+1.
- `done` is asserted in the same cycle that `playing` falls.
- `row_ticks` is sampled only at DECODE. Changes mid-row take effect on the next row.

## Test plan
- Reset with `rst`=0 mid-PLAY → all outputs 0 immediately (asynchronous), IDLE after release.
- Rows 0..3 = NOTE sin/sq/saw/rand, vol 15, pitch 10/20/30/40; row 4 = END; `loop_en`=0; `row_ticks`=4:
  - `row_strobe` every 6 cycles.
  - Outputs as written.
  - `done` at 2 cycles after row 3's PLAY ends, volume 0.
- Same pattern with `loop_en`=1 and END target 1 → row sequence 0,1,2,3,1,2,3…; 8 cycles between row 3's and row 1's strobes.
- Row 0 NOTE pitch 50 vol 9, row 1 HOLD, row 2 OFF, row 3 END → pitch 50 on all rows; volume 9, 9, 0.
- Rows 5 and 6 both END; row 5 targets 6 → `done` after the second decode, no livelock.
- `stop` mid-PLAY at row 2 → `volume`=0, `row`=2 next cycle, no `done`.
- Simultaneous `start`+`stop` → stays IDLE.
- `row_ticks`=0 → 3-cycle row period.
- `start_row`=DEPTH−1 with a NOTE in the last row → next row is 0.
